// File: rtl/mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one memory port between an instruction-fetch requester (i_*) and a
// data requester (d_*). One request is latched per grant and held on the
// memory port until mem_resp. The owner then gets a one-cycle response pulse.
//
// Handshake: a requester raises its request (i_read, or d_read/d_write) as a
// level and holds it, with a stable payload, until its x_resp pulse. In the
// cycle after x_resp it must drop the request or present a new one. Downstream,
// mem_read/mem_write stay high with a constant payload until mem_resp is
// sampled high. mem_resp is ignored outside a busy state.
//
// Parameters:
//   TIMEOUT_CYCLES  busy cycles without mem_resp before timeout_err sets
//                   (0 disables the check)
//
// Build option:
//   MEM_ARB_RR_EN   when defined, simultaneous requests alternate between the
//                   two requesters (round-robin). Otherwise D beats I.
//
// Ports:
//   clk, rst                  clock (rising edge), async active-high reset
//   i_read, i_address         fetch request
//   i_resp, i_rdata           fetch response pulse and data
//   d_read, d_write,
//   d_byte_enable, d_address,
//   d_wdata                   data request
//   d_resp, d_rdata           data response pulse and data
//   mem_read, mem_write,
//   mem_byte_enable,
//   mem_address, mem_wdata    downstream request (registered)
//   mem_resp, mem_rdata       downstream completion and read data
//   proto_err                 sticky: d_read and d_write both high in IDLE
//   timeout_err               sticky: a busy state reached the timeout
//   dbg_state                 FSM state (0 IDLE, 1 BUSY_I, 2 BUSY_D, 3 DONE)
//   dbg_last_d                last-served pointer (1 = data requester)
// ----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_read,
    input  logic [31:0] i_address,
    output logic        i_resp,
    output logic [31:0] i_rdata,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [3:0]  d_byte_enable,
    input  logic [31:0] d_address,
    input  logic [31:0] d_wdata,
    output logic        d_resp,
    output logic [31:0] d_rdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic [3:0]  mem_byte_enable,
    output logic [31:0] mem_address,
    output logic [31:0] mem_wdata,
    input  logic        mem_resp,
    input  logic [31:0] mem_rdata,
    output logic        proto_err,
    output logic        timeout_err,
    output logic [1:0]  dbg_state,
    output logic        dbg_last_d
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        DONE   = 2'd3
    } state_t;

    // The counter only has to reach TIMEOUT_CYCLES-1, where it saturates.
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    state_t           state_q;
    state_t           state_d;
    logic             last_d_q;   // last-served pointer, 0 = I, 1 = D
    logic             owner_d_q;  // owner of the transaction in flight
    logic [CNT_W-1:0] tmo_cnt_q;

    logic d_req;
    logic any_req;
    logic grant_d;

    // ------------------------------------------------------------------
    // Next-state and winner selection
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        d_req   = d_read | d_write;
        any_req = i_read | d_req;
        grant_d = 1'b0;
`ifdef MEM_ARB_RR_EN
        // On a tie, serve the requester that was not served last.
        if (i_read && d_req) begin
            grant_d = ~last_d_q;
        end else begin
            grant_d = d_req;
        end
`else
        grant_d = d_req;
`endif
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = grant_d ? BUSY_D : BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_resp) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Datapath: latched payload, responses, pointer, error flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_resp          <= 1'b0;
            i_rdata         <= '0;
            d_resp          <= 1'b0;
            d_rdata         <= '0;
            mem_read        <= 1'b0;
            mem_write       <= 1'b0;
            mem_byte_enable <= '0;
            mem_address     <= '0;
            mem_wdata       <= '0;
            proto_err       <= 1'b0;
            timeout_err     <= 1'b0;
            last_d_q        <= 1'b0;
            owner_d_q       <= 1'b0;
            tmo_cnt_q       <= '0;
        end else begin
            // Responses are single-cycle pulses raised only on mem_resp.
            i_resp <= 1'b0;
            d_resp <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (d_read && d_write) begin
                        proto_err <= 1'b1;
                    end
                    if (any_req) begin
                        owner_d_q <= grant_d;
                        if (grant_d) begin
                            // A read+write collision is granted as a write.
                            mem_read        <= d_read & ~d_write;
                            mem_write       <= d_write;
                            mem_byte_enable <= d_byte_enable;
                            mem_address     <= d_address;
                            mem_wdata       <= d_wdata;
                        end else begin
                            mem_read        <= 1'b1;
                            mem_write       <= 1'b0;
                            mem_byte_enable <= 4'hF;
                            mem_address     <= i_address;
                            mem_wdata       <= '0;
                        end
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (mem_resp) begin
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        tmo_cnt_q <= '0;
                        if (state_q == BUSY_D) begin
                            d_rdata <= mem_rdata;
                            d_resp  <= 1'b1;
                        end else begin
                            i_rdata <= mem_rdata;
                            i_resp  <= 1'b1;
                        end
                    end else begin
                        if (tmo_cnt_q != CNT_LAST) begin
                            tmo_cnt_q <= tmo_cnt_q + 1'b1;
                        end
                        // Flag only; the transaction keeps waiting.
                        if ((TIMEOUT_CYCLES != 0) && (tmo_cnt_q == CNT_LAST)) begin
                            timeout_err <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    last_d_q <= owner_d_q;
                end
                default: begin
                end
            endcase
        end
    end

    assign dbg_state  = state_q;
    assign dbg_last_d = last_d_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed and randomized bench for mem_port_arbiter (TIMEOUT_CYCLES = 8).
// Inputs are driven and outputs sampled on the falling clock edge. The bench
// plays the memory, answering each strobe after a chosen delay with data from
// mem_val(). Expected grant order is computed at transaction level from the
// pending request lists of both requesters and the arbitration rule.
// ----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        i_read = 1'b0;
    logic [31:0] i_address = '0;
    logic        i_resp;
    logic [31:0] i_rdata;
    logic        d_read = 1'b0;
    logic        d_write = 1'b0;
    logic [3:0]  d_byte_enable = '0;
    logic [31:0] d_address = '0;
    logic [31:0] d_wdata = '0;
    logic        d_resp;
    logic [31:0] d_rdata;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic        mem_resp = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        proto_err;
    logic        timeout_err;
    logic [1:0]  dbg_state;
    logic        dbg_last_d;

    mem_port_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_address(i_address), .i_resp(i_resp), .i_rdata(i_rdata),
        .d_read(d_read), .d_write(d_write), .d_byte_enable(d_byte_enable),
        .d_address(d_address), .d_wdata(d_wdata), .d_resp(d_resp), .d_rdata(d_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
        .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_resp(mem_resp), .mem_rdata(mem_rdata),
        .proto_err(proto_err), .timeout_err(timeout_err),
        .dbg_state(dbg_state), .dbg_last_d(dbg_last_d)
    );

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic        is_d;
        logic        rd;
        logic        wr;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    req_t i_pend[$];
    req_t d_pend[$];
    req_t exp_q[$];
    logic model_last_d = 1'b0;
    int   checks = 0;
    int   passed = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Memory contents seen by the bench's memory responder.
    function automatic logic [31:0] mem_val(input logic [31:0] a);
        if (a == 32'h60) return 32'h00000013;
        return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst = 1'b1;
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; mem_resp = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_last_d = 1'b0;
    endtask

    task automatic apply_heads();
        i_read = (i_pend.size() > 0);
        if (i_pend.size() > 0) i_address = i_pend[0].addr;
        d_read = 1'b0;
        d_write = 1'b0;
        if (d_pend.size() > 0) begin
            d_read        = d_pend[0].rd;
            d_write       = d_pend[0].wr;
            d_byte_enable = d_pend[0].be;
            d_address     = d_pend[0].addr;
            d_wdata       = d_pend[0].wdata;
        end
    endtask

    function automatic req_t mk_i(input logic [31:0] a);
        req_t r;
        r = '0;
        r.addr = a;
        r.rd = 1'b1;
        r.be = 4'hF;
        return r;
    endfunction

    function automatic req_t mk_d(input logic rd, input logic [3:0] be,
                                  input logic [31:0] a, input logic [31:0] wd);
        req_t r;
        r = '0;
        r.is_d = 1'b1;
        r.rd = rd;
        r.wr = ~rd;
        r.be = be;
        r.addr = a;
        r.wdata = wd;
        return r;
    endfunction

    // Serve everything in i_pend/d_pend. Every requester presents its next
    // request right after its response, so each arbitration sees the heads of
    // both lists.
    task automatic run_batch(input string name);
        req_t mi[$];
        req_t md[$];
        req_t cur;
        bit   take_d;
        bit   started;
        bit   prev_resp;
        int   wait_cnt;
        int   dly;
        int   served;
        int   total;
        mi = i_pend;
        md = d_pend;
        exp_q.delete();
        while (mi.size() > 0 || md.size() > 0) begin
            if (mi.size() > 0 && md.size() > 0) begin
`ifdef MEM_ARB_RR_EN
                take_d = !model_last_d;
`else
                take_d = 1'b1;
`endif
            end else begin
                take_d = (md.size() > 0);
            end
            if (take_d) exp_q.push_back(md.pop_front());
            else        exp_q.push_back(mi.pop_front());
            model_last_d = take_d;
        end
        total = exp_q.size();
        served = 0;
        started = 1'b0;
        prev_resp = 1'b0;
        wait_cnt = 0;
        dly = 0;
        apply_heads();
        for (int cyc = 0; cyc < 400 && served < total; cyc++) begin
            @(negedge clk);
            if (prev_resp) check({name, " resp_one_cycle"}, {30'd0, i_resp, d_resp}, 32'd0);
            prev_resp = 1'b0;
            if (mem_resp) begin
                mem_resp = 1'b0;
            end else if ((mem_read || mem_write) && exp_q.size() > 0) begin
                if (!started) begin
                    started = 1'b1;
                    wait_cnt = 0;
                    dly = $urandom_range(0, 4);
                    cur = exp_q[0];
                    check({name, " mem_address"}, mem_address, cur.addr);
                    check({name, " strobes"}, {30'd0, mem_read, mem_write},
                          cur.is_d ? {30'd0, cur.rd, cur.wr} : 32'd2);
                    check({name, " mask"}, {28'd0, mem_byte_enable},
                          cur.is_d ? {28'd0, cur.be} : 32'hF);
                    if (cur.wr) check({name, " mem_wdata"}, mem_wdata, cur.wdata);
                end
                if (wait_cnt == dly) begin
                    mem_resp = 1'b1;
                    mem_rdata = mem_val(mem_address);
                end else begin
                    wait_cnt++;
                end
            end
            if (i_resp || d_resp) begin
                if (exp_q.size() > 0) begin
                    cur = exp_q.pop_front();
                    check({name, " owner"}, {30'd0, i_resp, d_resp}, cur.is_d ? 32'd1 : 32'd2);
                    if (cur.is_d && cur.rd) check({name, " d_rdata"}, d_rdata, mem_val(cur.addr));
                    if (!cur.is_d) check({name, " i_rdata"}, i_rdata, mem_val(cur.addr));
                end
                if (d_resp && d_pend.size() > 0) void'(d_pend.pop_front());
                if (i_resp && i_pend.size() > 0) void'(i_pend.pop_front());
                served++;
                started = 1'b0;
                prev_resp = 1'b1;
                apply_heads();
            end
        end
        check({name, " served_count"}, served, total);
        i_pend.delete();
        d_pend.delete();
        apply_heads();
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        do_reset();

        // Reset state.
        @(negedge clk);
        check("rst_state", {30'd0, dbg_state}, 32'd0);
        check("rst_strobes", {30'd0, mem_read, mem_write}, 32'd0);
        check("rst_resps", {30'd0, i_resp, d_resp}, 32'd0);
        check("rst_mask", {28'd0, mem_byte_enable}, 32'd0);
        check("rst_address", mem_address, 32'd0);
        check("rst_errs", {30'd0, proto_err, timeout_err}, 32'd0);
        check("rst_pointer", {31'd0, dbg_last_d}, 32'd0);

        // A mem_resp while idle is ignored.
        mem_resp = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        mem_resp = 1'b0;
        @(negedge clk);
        check("stray_resp", {30'd0, i_resp, d_resp}, 32'd0);
        check("stray_state", {30'd0, dbg_state}, 32'd0);

        // Lone fetch, memory answers 3 cycles after mem_read.
        i_read = 1'b1;
        i_address = 32'h60;
        @(negedge clk);
        check("fetch_strobes", {30'd0, mem_read, mem_write}, 32'd2);
        check("fetch_mask", {28'd0, mem_byte_enable}, 32'hF);
        check("fetch_address", mem_address, 32'h60);
        repeat (3) @(negedge clk);
        mem_resp = 1'b1;
        mem_rdata = mem_val(32'h60);
        @(negedge clk);
        mem_resp = 1'b0;
        check("fetch_resp", {30'd0, i_resp, d_resp}, 32'd2);
        check("fetch_rdata", i_rdata, 32'h00000013);
        check("fetch_strobe_drop", {31'd0, mem_read}, 32'd0);
        i_read = 1'b0;
        @(negedge clk);
        check("fetch_resp_pulse", {30'd0, i_resp, d_resp}, 32'd0);
        model_last_d = 1'b0;

        // Simultaneous fetch + data write.
        i_pend.push_back(mk_i(32'h40));
        d_pend.push_back(mk_d(1'b0, 4'b0011, 32'h100, 32'hDEADBEEF));
        run_batch("simul1");
        // Data requester replaces its request right after being served.
        i_pend.push_back(mk_i(32'h44));
        d_pend.push_back(mk_d(1'b0, 4'b0011, 32'h100, 32'hDEADBEEF));
        d_pend.push_back(mk_d(1'b1, 4'hF, 32'h104, 32'h0));
        run_batch("simul2");

        // Random batches.
        for (int b = 0; b < 8; b++) begin
            int ni;
            int nd;
            ni = $urandom_range(0, 3);
            nd = $urandom_range(0, 3);
            for (int k = 0; k < ni; k++) i_pend.push_back(mk_i($urandom & 32'h0000FFFC));
            for (int k = 0; k < nd; k++)
                d_pend.push_back(mk_d(1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)),
                                      $urandom & 32'h0000FFFC, $urandom));
            run_batch("rnd");
        end
        @(negedge clk);
        check("rnd_no_errs", {30'd0, proto_err, timeout_err}, 32'd0);

        // Payload stays stable while busy.
        d_write = 1'b1;
        d_byte_enable = 4'b0011;
        d_address = 32'h100;
        d_wdata = 32'hDEADBEEF;
        @(negedge clk);
        check("stable_write", {30'd0, mem_read, mem_write}, 32'd1);
        d_address = 32'h200;
        d_byte_enable = 4'hF;
        d_wdata = 32'h0;
        repeat (2) @(negedge clk);
        check("stable_address", mem_address, 32'h100);
        check("stable_mask", {28'd0, mem_byte_enable}, 32'h3);
        check("stable_wdata", mem_wdata, 32'hDEADBEEF);
        mem_resp = 1'b1;
        @(negedge clk);
        mem_resp = 1'b0;
        d_write = 1'b0;
        check("stable_resp", {30'd0, i_resp, d_resp}, 32'd1);
        @(negedge clk);

        // Read and write together: protocol error, granted as write.
        d_read = 1'b1;
        d_write = 1'b1;
        d_address = 32'h180;
        @(negedge clk);
        check("proto_err_set", {31'd0, proto_err}, 32'd1);
        check("proto_as_write", {30'd0, mem_read, mem_write}, 32'd1);
        mem_resp = 1'b1;
        @(negedge clk);
        mem_resp = 1'b0;
        d_read = 1'b0;
        d_write = 1'b0;
        check("proto_resp", {30'd0, i_resp, d_resp}, 32'd1);
        repeat (2) @(negedge clk);
        check("proto_err_sticky", {31'd0, proto_err}, 32'd1);

        // Timeout: memory silent, flag after 8 busy cycles, late response ok.
        i_read = 1'b1;
        i_address = 32'h80;
        @(negedge clk);
        check("tmo_mem_read", {31'd0, mem_read}, 32'd1);
        repeat (7) @(negedge clk);
        check("tmo_not_yet", {31'd0, timeout_err}, 32'd0);
        @(negedge clk);
        check("tmo_set", {31'd0, timeout_err}, 32'd1);
        check("tmo_still_reading", {31'd0, mem_read}, 32'd1);
        mem_resp = 1'b1;
        mem_rdata = mem_val(32'h80);
        @(negedge clk);
        mem_resp = 1'b0;
        i_read = 1'b0;
        check("tmo_late_resp", {30'd0, i_resp, d_resp}, 32'd2);
        check("tmo_late_rdata", i_rdata, mem_val(32'h80));
        @(negedge clk);
        check("tmo_sticky", {31'd0, timeout_err}, 32'd1);

        // Reset in the middle of a fetch.
        i_read = 1'b1;
        i_address = 32'h90;
        @(negedge clk);
        check("rstmid_busy", {31'd0, mem_read}, 32'd1);
        #2 rst = 1'b1;
        #1 check("rstmid_async_drop", {31'd0, mem_read}, 32'd0);
        i_read = 1'b0;
        d_read = 1'b1;
        d_byte_enable = 4'b1100;
        d_address = 32'h300;
        @(negedge clk);
        check("rstmid_no_resp", {30'd0, i_resp, d_resp}, 32'd0);
        check("rstmid_errs_clear", {30'd0, proto_err, timeout_err}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rstmid_fresh_grant", {30'd0, mem_read, mem_write}, 32'd2);
        check("rstmid_address", mem_address, 32'h300);
        check("rstmid_mask", {28'd0, mem_byte_enable}, 32'hC);
        mem_resp = 1'b1;
        mem_rdata = mem_val(32'h300);
        @(negedge clk);
        mem_resp = 1'b0;
        d_read = 1'b0;
        check("rstmid_d_resp", {30'd0, i_resp, d_resp}, 32'd1);
        check("rstmid_d_rdata", d_rdata, mem_val(32'h300));
        @(negedge clk);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
